node_controller: RTL and testbench
==================================

NODE_CONTROLLER -- requirements
Module: node_controller

Interface
REQ-001 SHALL have parameter IMAGE_SIZE, default 64, meaning number of coef/data pairs accumulated per evaluation (legal 2..128).
REQ-002 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port go  input  1  request one node evaluation, sampled in IDLE only.
REQ-005 SHALL have port abort  input  1  cancel evaluation in progress.
REQ-006 SHALL have port node_out  input  16  activated node result from the node datapath.
REQ-007 SHALL have port result_ready  input  1  downstream accepts result.
REQ-008 SHALL have port reset_acc  output  1  high clears node accumulator at next edge.
REQ-009 SHALL have port start  output  1  high = node accumulator holds, low = node accumulates product at cnt_val.
REQ-010 SHALL have port cnt_val  output  7  index of coef/data pair presented to node.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a result is captured.
REQ-013 SHALL have port result  output  16  captured node_out.
REQ-014 SHALL have port result_valid  output  1  result holds an unconsumed value.

Function
REQ-015 SHALL implement states IDLE, CLEAR, ACCUM, SETTLE; all outputs registered or decoded from registered state only.
REQ-016 IDLE: reset_acc=0, start=1, cnt_val=0; go=1 -> CLEAR; otherwise stay.
REQ-017 CLEAR (exactly 1 cycle): reset_acc=1, start=1, cnt_val=0; -> ACCUM.
REQ-018 ACCUM (exactly IMAGE_SIZE cycles): reset_acc=0, start=0, cnt_val counts 0,1,...,IMAGE_SIZE-1, incrementing by 1 each cycle.
REQ-019 ACCUM with cnt_val=IMAGE_SIZE-1 -> SETTLE, cnt_val wraps to 0; no value >= IMAGE_SIZE SHALL ever appear on cnt_val.
REQ-020 SETTLE: reset_acc=0, start=1 (accumulator held), cnt_val=0.
REQ-021 SETTLE with result slot free (result_valid=0, or result_valid=1 and result_ready=1 same edge): result<=node_out, result_valid<=1, done pulses 1 cycle, -> IDLE.
REQ-022 SETTLE with slot occupied (result_valid=1, result_ready=0): stay in SETTLE, accumulator held, no capture, no done.
REQ-023 Latency: go sampled at edge E0 -> result_valid and done high after edge E0+IMAGE_SIZE+2 when slot free (66 edges for default).
REQ-024 result_valid=1 and result_ready=1 at an edge with no capture -> result_valid<=0; result unchanged.
REQ-025 result and result_valid SHALL stay stable while result_valid=1 and result_ready=0.
REQ-026 go while busy=1 SHALL be ignored (no queuing); go in IDLE with result_valid=1 SHALL be accepted.
REQ-027 abort=1 in CLEAR, ACCUM or SETTLE -> IDLE at next edge, cnt_val=0, no capture, no done; result/result_valid untouched.
REQ-028 abort has priority over go and over SETTLE capture; abort in IDLE has no effect, including go same cycle (go ignored).
REQ-029 Back-to-back: go held high SHALL start a new evaluation the cycle after returning to IDLE (one IDLE cycle between evaluations).

Reset
REQ-030 n_rst=0 SHALL asynchronously force IDLE, cnt_val=0, reset_acc=0, start=1, busy=0, done=0, result=16'h0000, result_valid=0.
REQ-031 n_rst deassertion mid-operation SHALL resume from IDLE only; no partial evaluation SHALL continue.

Verification
REQ-032 go pulse, result_valid=0, node_out model = sum of 64 products, result_ready=1 -> CLEAR 1 cycle, cnt_val 0..63 with start=0, done and result_valid after 66 edges, result equals model value.
REQ-033 result_valid=1 held with result_ready=0, second evaluation reaches SETTLE -> stays in SETTLE, start=1, no done; raise result_ready -> capture same edge, result_valid remains 1 with new value, done pulses.
REQ-034 abort asserted at cnt_val=30 -> IDLE next edge, busy=0, cnt_val=0, no done, prior result/result_valid unchanged.
REQ-035 go pulsed at cnt_val=10 and in CLEAR -> ignored; exactly one done per accepted go.
REQ-036 n_rst pulsed low at cnt_val=40 -> all outputs at reset values immediately, result_valid=0; next go yields full 66-edge evaluation.
REQ-037 IMAGE_SIZE=2 build: go -> cnt_val 0,1 only, done after 4 edges; IMAGE_SIZE=128: cnt_val reaches 127, never wraps to 0 inside ACCUM.

Source files
------------

// File: rtl/node_controller.sv
// Sequencer for one neuron evaluation: clears the node accumulator, walks the
// coef/data index across the image, then captures the activated result.
module node_controller #(
   parameter int IMAGE_SIZE = 64
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        go,
   input  logic        abort,
   input  logic [15:0] node_out,
   input  logic        result_ready,
   output logic        reset_acc,
   output logic        start,
   output logic [6:0]  cnt_val,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        result_valid
);

   typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, SETTLE} state_t;

   localparam logic [6:0] LAST_IDX = 7'(IMAGE_SIZE - 1);

   state_t state;
   logic   slot_free;

   // The result slot can take a new value when empty or being drained this edge.
   assign slot_free = !result_valid || result_ready;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state        <= IDLE;
         reset_acc    <= 1'b0;
         start        <= 1'b1;
         cnt_val      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         done <= 1'b0;
         if (result_valid && result_ready)
            result_valid <= 1'b0;

         // Abort beats both go and capture; it never touches the result slot.
         if (abort && state != IDLE) begin
            state     <= IDLE;
            reset_acc <= 1'b0;
            start     <= 1'b1;
            cnt_val   <= '0;
            busy      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (go && !abort) begin
                     state     <= CLEAR;
                     reset_acc <= 1'b1;
                     start     <= 1'b1;
                     cnt_val   <= '0;
                     busy      <= 1'b1;
                  end
               end
               CLEAR: begin
                  state     <= ACCUM;
                  reset_acc <= 1'b0;
                  start     <= 1'b0;
                  cnt_val   <= '0;
               end
               ACCUM: begin
                  if (cnt_val == LAST_IDX) begin
                     state   <= SETTLE;
                     start   <= 1'b1;
                     cnt_val <= '0;
                  end else begin
                     cnt_val <= cnt_val + 7'd1;
                  end
               end
               SETTLE: begin
                  if (slot_free) begin
                     result       <= node_out;
                     result_valid <= 1'b1;
                     done         <= 1'b1;
                     busy         <= 1'b0;
                     state        <= IDLE;
                  end
               end
               default: begin
                  state     <= IDLE;
                  reset_acc <= 1'b0;
                  start     <= 1'b1;
                  cnt_val   <= '0;
                  busy      <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_node_controller.sv
// Bench for node_controller: a behavioural node accumulator feeds node_out and a
// scoreboard queue holds the sum-of-products expected at each done pulse.
module tb_node_controller;

   localparam int N = 64;

   logic        clk = 1'b0;
   logic        n_rst, go, abort, result_ready;
   logic [15:0] node_out;
   logic        reset_acc, start, busy, done, result_valid;
   logic [6:0]  cnt_val;
   logic [15:0] result;

   logic        go_s, reset_acc_s, start_s, busy_s, done_s, result_valid_s;
   logic [6:0]  cnt_s;
   logic [15:0] result_s;
   logic        go_l, reset_acc_l, start_l, busy_l, done_l, result_valid_l;
   logic [6:0]  cnt_l;
   logic [15:0] result_l;

   logic [7:0]  coef [128];
   logic [7:0]  data [128];
   logic [15:0] acc = '0;
   logic [15:0] exp_q [$];
   logic [15:0] last_res;
   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   int          npush = 0;

   always #5 clk = ~clk;

   node_controller #(.IMAGE_SIZE(N)) u_dut (
      .clk(clk), .n_rst(n_rst), .go(go), .abort(abort), .node_out(node_out),
      .result_ready(result_ready), .reset_acc(reset_acc), .start(start),
      .cnt_val(cnt_val), .busy(busy), .done(done), .result(result),
      .result_valid(result_valid));

   node_controller #(.IMAGE_SIZE(2)) u_small (
      .clk(clk), .n_rst(n_rst), .go(go_s), .abort(1'b0), .node_out(16'hA5C3),
      .result_ready(1'b1), .reset_acc(reset_acc_s), .start(start_s),
      .cnt_val(cnt_s), .busy(busy_s), .done(done_s), .result(result_s),
      .result_valid(result_valid_s));

   node_controller #(.IMAGE_SIZE(128)) u_large (
      .clk(clk), .n_rst(n_rst), .go(go_l), .abort(1'b0), .node_out(16'h5A3C),
      .result_ready(1'b1), .reset_acc(reset_acc_l), .start(start_l),
      .cnt_val(cnt_l), .busy(busy_l), .done(done_l), .result(result_l),
      .result_valid(result_valid_l));

   // Node datapath model: clear on reset_acc, accumulate while start is low.
   always @(posedge clk) begin
      if (reset_acc)
         acc <= '0;
      else if (!start)
         acc <= acc + {8'd0, coef[cnt_val]} * {8'd0, data[cnt_val]};
   end
   assign node_out = acc;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_cnt"}, 32'(cnt_val), 0);
      chk({tag, "_start"}, 32'(start), 1);
      chk({tag, "_reset_acc"}, 32'(reset_acc), 0);
      chk({tag, "_done"}, 32'(done), 0);
   endtask

   // Scoreboard side: every done pops one expected result.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (n_rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0)
               chk("done_unexpected", 32'(done), 0);
            else
               chk("sb_result", 32'(result), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic run_eval(input int go_at, input int abort_at, input int rst_at,
                           input bit hold_go, input int hold_cycles);
      logic [15:0] s;
      logic        rv_b;
      s = '0;
      for (int i = 0; i < N; i++) begin
         coef[i] = 8'($urandom);
         data[i] = 8'($urandom);
         s = s + {8'd0, coef[i]} * {8'd0, data[i]};
      end
      if (abort_at < 0 && rst_at < 0) begin
         exp_q.push_back(s);
         npush++;
      end
      go = 1'b1;
      step();
      go = hold_go || (go_at == -1);
      chk("clear_reset_acc", 32'(reset_acc), 1);
      chk("clear_start", 32'(start), 1);
      chk("clear_busy", 32'(busy), 1);
      chk("clear_cnt", 32'(cnt_val), 0);
      step();
      go = hold_go;
      for (int i = 0; i < N; i++) begin
         chk("accum_cnt", 32'(cnt_val), 32'(i));
         chk("accum_start", 32'(start), 0);
         chk("accum_reset_acc", 32'(reset_acc), 0);
         chk("accum_busy", 32'(busy), 1);
         if (i == abort_at) begin
            rv_b = result_valid;
            abort = 1'b1;
            go = 1'b1;
            step();
            abort = 1'b0;
            go = 1'b0;
            chk_idle("abort");
            chk("abort_rv", 32'(result_valid), 32'(rv_b && !result_ready));
            chk("abort_result", 32'(result), 32'(last_res));
            return;
         end
         if (i == rst_at) begin
            n_rst = 1'b0;
            #1;
            chk_idle("rst");
            chk("rst_result", 32'(result), 0);
            chk("rst_rv", 32'(result_valid), 0);
            last_res = '0;
            step();
            n_rst = 1'b1;
            step();
            chk_idle("rst_resume");
            return;
         end
         go = hold_go || (i == go_at);
         step();
         go = hold_go;
      end
      chk("settle_start", 32'(start), 1);
      chk("settle_cnt", 32'(cnt_val), 0);
      chk("settle_reset_acc", 32'(reset_acc), 0);
      chk("settle_busy", 32'(busy), 1);
      chk("settle_done", 32'(done), 0);
      for (int h = 0; h < hold_cycles; h++) begin
         step();
         chk("hold_busy", 32'(busy), 1);
         chk("hold_start", 32'(start), 1);
         chk("hold_done", 32'(done), 0);
         chk("hold_rv", 32'(result_valid), 1);
         chk("hold_result", 32'(result), 32'(last_res));
      end
      if (hold_cycles > 0)
         result_ready = 1'b1;
      step();
      chk("cap_done", 32'(done), 1);
      chk("cap_rv", 32'(result_valid), 1);
      chk("cap_busy", 32'(busy), 0);
      chk("cap_result", 32'(result), 32'(s));
      last_res = s;
      step();
      chk("post_done", 32'(done), 0);
      chk("post_rv", 32'(result_valid), 32'(!result_ready));
      chk("post_result", 32'(result), 32'(last_res));
      if (hold_go) begin
         chk("b2b_busy", 32'(busy), 1);
         chk("b2b_reset_acc", 32'(reset_acc), 1);
         abort = 1'b1;
         go = 1'b0;
         step();
         abort = 1'b0;
         chk_idle("b2b_abort");
      end else begin
         chk("post_busy", 32'(busy), 0);
      end
   endtask

   initial begin
      n_rst = 1'b1;
      go = 1'b0;
      abort = 1'b0;
      result_ready = 1'b1;
      go_s = 1'b0;
      go_l = 1'b0;
      last_res = '0;
      #3;
      n_rst = 1'b0;
      #1;
      chk_idle("por");
      chk("por_result", 32'(result), 0);
      chk("por_rv", 32'(result_valid), 0);
      step();
      step();
      n_rst = 1'b1;
      step();
      chk_idle("por_release");

      run_eval(-2, -1, -1, 1'b0, 0);          // basic evaluation
      result_ready = 1'b0;
      run_eval(-2, -1, -1, 1'b0, 0);          // capture into empty slot, keep it
      run_eval(-2, -1, -1, 1'b0, 3);          // stall in SETTLE, then drain+capture
      result_ready = 1'b0;
      run_eval(-2, -1, -1, 1'b0, 0);
      run_eval(-2, 30, -1, 1'b0, 0);          // abort with a held result
      result_ready = 1'b1;
      step();
      chk("drain_rv", 32'(result_valid), 0);

      abort = 1'b1;
      go = 1'b1;
      step();
      abort = 1'b0;
      go = 1'b0;
      chk_idle("abort_idle_go");

      run_eval(-1, -1, -1, 1'b0, 0);          // go during CLEAR ignored
      run_eval(10, -1, -1, 1'b0, 0);          // go during ACCUM ignored
      run_eval(-2, -1, -1, 1'b1, 0);          // go held high: back-to-back restart
      run_eval(-2, -1, 40, 1'b0, 0);          // reset mid-evaluation
      run_eval(-2, -1, -1, 1'b0, 0);
      repeat (4) step();
      chk("done_count", 32'(done_cnt), 32'(npush));
      chk("queue_empty", 32'(exp_q.size()), 0);

      go_s = 1'b1;
      step();
      go_s = 1'b0;
      chk("s_clear", 32'(reset_acc_s), 1);
      chk("s_busy", 32'(busy_s), 1);
      step();
      chk("s_cnt0", 32'(cnt_s), 0);
      chk("s_start0", 32'(start_s), 0);
      step();
      chk("s_cnt1", 32'(cnt_s), 1);
      chk("s_start1", 32'(start_s), 0);
      step();
      chk("s_settle", 32'(start_s), 1);
      chk("s_settle_cnt", 32'(cnt_s), 0);
      chk("s_settle_done", 32'(done_s), 0);
      step();
      chk("s_done", 32'(done_s), 1);
      chk("s_rv", 32'(result_valid_s), 1);
      chk("s_result", 32'(result_s), 32'h0000A5C3);

      go_l = 1'b1;
      step();
      go_l = 1'b0;
      chk("l_clear", 32'(reset_acc_l), 1);
      for (int i = 0; i < 128; i++) begin
         step();
         chk("l_cnt", 32'(cnt_l), 32'(i));
         chk("l_start", 32'(start_l), 0);
         chk("l_busy", 32'(busy_l), 1);
      end
      step();
      chk("l_settle", 32'(start_l), 1);
      chk("l_settle_cnt", 32'(cnt_l), 0);
      step();
      chk("l_done", 32'(done_l), 1);
      chk("l_rv", 32'(result_valid_l), 1);
      chk("l_result", 32'(result_l), 32'h00005A3C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
